// File: rtl/serial_tx_arbiter_if.sv
// Bus between the requesters and the round-robin serial transmit scheduler.
// The arbiter takes the slave modport; requesters (or a bench) take master.
interface serial_tx_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]   req;
  logic [7*N_REQ-1:0] data_in;
  logic [N_REQ-1:0]   grant;
  logic               serial_out;
  logic               busy;
  logic [ID_W-1:0]    cur_id;
  logic               frame_done;

  modport master (
    output req, data_in,
    input  grant, serial_out, busy, cur_id, frame_done
  );

  modport slave (
    input  req, data_in,
    output grant, serial_out, busy, cur_id, frame_done
  );
endinterface

// File: rtl/serial_tx_arbiter.sv
// Round-robin scheduler sharing one serial line between N_REQ requesters.
// Frame: start bit, 7 data bits LSB first, even parity, STOP_CYCLES stop bits.
module serial_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int ID_W        = 2,
  parameter int STOP_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rstn,
  serial_tx_arbiter_if.slave tx_if
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam int              SC_W      = (STOP_CYCLES > 1) ? $clog2(STOP_CYCLES) : 1;
  localparam logic [SC_W-1:0] STOP_LAST = SC_W'(STOP_CYCLES - 1);

  logic [2:0]       r_state;
  logic [2:0]       r_bit_cnt;
  logic [SC_W-1:0]  r_stop_cnt;
  logic [ID_W-1:0]  r_last_id;
  logic [ID_W-1:0]  r_cur_id;
  logic [N_REQ-1:0] r_grant;
  logic             r_serial;
  logic             r_busy;
  logic             r_frame_done;
  logic [6:0]       r_shift;
  logic             r_parity;

  logic [2*N_REQ-1:0] w_req_dbl;
  logic [N_REQ-1:0]   w_req_rot;
  logic               w_win_vld;
  logic [ID_W-1:0]    w_off;
  int                 w_sum;
  logic [ID_W-1:0]    w_win_id;
  logic [6:0]         w_win_word;
  logic [N_REQ-1:0]   w_onehot;
  logic               w_arb_edge;
  logic               w_launch;

  // Rotate req so bit 0 is the requester right after the last grantee.
  assign w_req_dbl = {tx_if.req, tx_if.req};
  assign w_req_rot = N_REQ'(w_req_dbl >> (r_last_id + ID_W'(1)));

  always_comb begin
    w_win_vld = 1'b0;
    w_off     = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (w_req_rot[j]) begin
        w_win_vld = 1'b1;
        w_off     = ID_W'(j);
      end
    end
  end

  always_comb begin
    w_sum = int'(r_last_id) + 1 + int'(w_off);
    if (w_sum >= N_REQ) begin
      w_sum = w_sum - N_REQ;
    end
  end

  assign w_win_id = ID_W'(w_sum);
  assign w_onehot = N_REQ'(1) << w_win_id;

  always_comb begin
    w_win_word = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (ID_W'(j) == w_win_id) begin
        w_win_word = tx_if.data_in[7*j +: 7];
      end
    end
  end

  // Arbitration happens in IDLE and at the end of the final stop cycle only.
  assign w_arb_edge = (r_state == S_IDLE) ||
                      ((r_state == S_STOP) && (r_stop_cnt == STOP_LAST));
  assign w_launch   = w_arb_edge && w_win_vld;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_stop_cnt   <= '0;
      r_last_id    <= ID_W'(N_REQ - 1);
      r_cur_id     <= '0;
      r_grant      <= '0;
      r_serial     <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_grant      <= '0;
      r_frame_done <= 1'b0;
      if (w_launch) begin
        r_state   <= S_START;
        r_grant   <= w_onehot;
        r_cur_id  <= w_win_id;
        r_last_id <= w_win_id;
        r_busy    <= 1'b1;
        r_serial  <= 1'b0;
      end else begin
        unique case (r_state)
          S_START: begin
            r_state   <= S_DATA;
            r_bit_cnt <= '0;
            r_serial  <= r_shift[0];
          end
          S_DATA: begin
            if (r_bit_cnt == 3'd6) begin
              r_state  <= S_PARITY;
              r_serial <= r_parity;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_serial  <= r_shift[r_bit_cnt + 3'd1];
            end
          end
          S_PARITY: begin
            r_state      <= S_STOP;
            r_stop_cnt   <= '0;
            r_serial     <= 1'b1;
            r_frame_done <= (STOP_LAST == '0);
          end
          S_STOP: begin
            r_serial <= 1'b1;
            if (r_stop_cnt == STOP_LAST) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_stop_cnt   <= r_stop_cnt + SC_W'(1);
              r_frame_done <= ((r_stop_cnt + SC_W'(1)) == STOP_LAST);
            end
          end
          default: begin
            r_state  <= S_IDLE;
            r_serial <= 1'b1;
            r_busy   <= 1'b0;
          end
        endcase
      end
    end
  end

  // Word and parity are captured only at a grant; they need no reset.
  always_ff @(posedge clk) begin
    if (w_launch) begin
      r_shift  <= w_win_word;
      r_parity <= ^w_win_word;
    end
  end

  assign tx_if.grant      = r_grant;
  assign tx_if.serial_out = r_serial;
  assign tx_if.busy       = r_busy;
  assign tx_if.cur_id     = r_cur_id;
  assign tx_if.frame_done = r_frame_done;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: two instances (1 and 3 stop cycles) checked
// against a frame/round-robin reference model.
module tb_serial_tx_arbiter;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  serial_tx_arbiter_if #(.N_REQ(4), .ID_W(2)) if_a ();
  serial_tx_arbiter_if #(.N_REQ(4), .ID_W(2)) if_b ();

  serial_tx_arbiter #(.N_REQ(4), .ID_W(2), .STOP_CYCLES(1)) u_dut_a (
    .clk(clk), .rstn(rstn), .tx_if(if_a)
  );
  serial_tx_arbiter #(.N_REQ(4), .ID_W(2), .STOP_CYCLES(3)) u_dut_b (
    .clk(clk), .rstn(rstn), .tx_if(if_b)
  );

  int errors = 0;
  int checks = 0;
  int mdl_last;

  logic       cap_line [64];
  logic       cap_busy [64];
  logic       cap_fd   [64];
  logic [3:0] cap_grant[64];

  // Expected line level t cycles after the start bit.
  function automatic logic exp_line(input logic [6:0] w, input int t);
    logic [6:0] tmp;
    if (t == 0) return 1'b0;
    if (t <= 7) begin
      tmp = w >> (t - 1);
      return tmp[0];
    end
    if (t == 8) return ^w;
    return 1'b1;
  endfunction

  // Round-robin: first requester after 'last', wrapping modulo 4.
  function automatic int rr_pick(input int last, input logic [3:0] r);
    int pick;
    int idx;
    pick = -1;
    for (int k = 1; k <= 4; k++) begin
      idx = (last + k) % 4;
      if (pick < 0 && ((r >> idx) & 4'd1) != 4'd0) pick = idx;
    end
    return pick;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cap(input bit use_b, input int n);
    for (int t = 0; t < n; t++) begin
      if (use_b) begin
        cap_line[t] = if_b.serial_out; cap_busy[t] = if_b.busy;
        cap_fd[t] = if_b.frame_done;   cap_grant[t] = if_b.grant;
      end else begin
        cap_line[t] = if_a.serial_out; cap_busy[t] = if_a.busy;
        cap_fd[t] = if_a.frame_done;   cap_grant[t] = if_a.grant;
      end
      tick();
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    if_a.req = '0;
    if_b.req = '0;
    tick();
    tick();
    rstn = 1'b1;
    mdl_last = 3;
  endtask

  task automatic test_reset();
    logic [8:0] got;
    rstn = 1'b0;
    if_a.req = '0; if_a.data_in = '0;
    if_b.req = '0; if_b.data_in = '0;
    tick();
    tick();
    got = {if_a.serial_out, if_a.busy, if_a.grant, if_a.cur_id, if_a.frame_done};
    checks++;
    if (got !== 9'b1_0_0000_00_0) begin
      errors++; $display("FAIL reset_a: got %b want %b", got, 9'b1_0_0000_00_0);
    end
    got = {if_b.serial_out, if_b.busy, if_b.grant, if_b.cur_id, if_b.frame_done};
    checks++;
    if (got !== 9'b1_0_0000_00_0) begin
      errors++; $display("FAIL reset_b: got %b want %b", got, 9'b1_0_0000_00_0);
    end
    rstn = 1'b1;
    mdl_last = 3;
  endtask

  task automatic test_single();
    logic [6:0] rx;
    logic       pok_n;
    if_a.data_in = '0;
    if_a.data_in[14 +: 7] = 7'h55;
    if_a.req = 4'b0100;
    tick();
    checks++;
    if ({if_a.grant, if_a.cur_id} !== {4'b0100, 2'd2}) begin
      errors++; $display("FAIL single_grant: got %b/%0d want 0100/2", if_a.grant, if_a.cur_id);
    end
    mdl_last = 2;
    if_a.req = '0;
    cap(1'b0, 11);
    for (int t = 0; t <= 10; t++) begin
      checks++;
      if ({cap_line[t], cap_busy[t], cap_fd[t], cap_grant[t]} !==
          {exp_line(7'h55, t), (t <= 9), (t == 9), (t == 0) ? 4'b0100 : 4'b0000}) begin
        errors++;
        $display("FAIL single_t%0d: got line=%b busy=%b fd=%b grant=%b want line=%b busy=%b fd=%b",
                 t, cap_line[t], cap_busy[t], cap_fd[t], cap_grant[t],
                 exp_line(7'h55, t), (t <= 9), (t == 9));
      end
    end
    for (int i = 0; i < 7; i++) rx[i] = cap_line[i+1];
    pok_n = 1'b0;
    for (int i = 1; i <= 8; i++) pok_n = pok_n ^ cap_line[i];
    checks++;
    if ({rx, pok_n} !== {7'h55, 1'b0}) begin
      errors++; $display("FAIL single_rx: got data=%h pok_n=%b want 55/0", rx, pok_n);
    end
  endtask

  task automatic test_stop3();
    logic pok_n;
    if_b.data_in = '0;
    if_b.data_in[0 +: 7] = 7'h01;
    if_b.req = 4'b0001;
    tick();
    checks++;
    if (if_b.grant !== 4'b0001) begin
      errors++; $display("FAIL stop3_grant: got %b want 0001", if_b.grant);
    end
    if_b.req = '0;
    cap(1'b1, 13);
    checks++;
    if (cap_line[8] !== 1'b1) begin
      errors++; $display("FAIL stop3_parity: got %b want 1", cap_line[8]);
    end
    for (int t = 0; t <= 12; t++) begin
      checks++;
      if ({cap_line[t], cap_busy[t], cap_fd[t]} !==
          {exp_line(7'h01, t), (t <= 11), (t == 11)}) begin
        errors++;
        $display("FAIL stop3_t%0d: got line=%b busy=%b fd=%b want line=%b busy=%b fd=%b",
                 t, cap_line[t], cap_busy[t], cap_fd[t], exp_line(7'h01, t), (t <= 11), (t == 11));
      end
    end
    pok_n = 1'b0;
    for (int i = 1; i <= 8; i++) pok_n = pok_n ^ cap_line[i];
    checks++;
    if (pok_n !== 1'b0) begin
      errors++; $display("FAIL stop3_rx_parity: got %b want 0", pok_n);
    end
  endtask

  // Held requests: frames every 10 cycles, grants follow round-robin.
  task automatic run_held(input string nm, input logic [3:0] mask, input logic [6:0] wd [4]);
    int e [4];
    int e5;
    for (int i = 0; i < 4; i++) if_a.data_in[7*i +: 7] = wd[i];
    if_a.req = mask;
    tick();
    cap(1'b0, 40);
    for (int f = 0; f < 4; f++) begin
      e[f] = rr_pick(mdl_last, mask);
      mdl_last = e[f];
    end
    for (int t = 0; t < 40; t++) begin
      checks++;
      if ({cap_line[t], cap_busy[t], cap_grant[t]} !==
          {exp_line(wd[e[t/10]], t % 10), 1'b1,
           (t % 10 == 0) ? (4'b0001 << e[t/10]) : 4'b0000}) begin
        errors++;
        $display("FAIL %s_t%0d: got line=%b busy=%b grant=%b want line=%b busy=1 id=%0d",
                 nm, t, cap_line[t], cap_busy[t], cap_grant[t], exp_line(wd[e[t/10]], t % 10), e[t/10]);
      end
    end
    e5 = rr_pick(mdl_last, mask);
    mdl_last = e5;
    checks++;
    if (if_a.grant !== (4'b0001 << e5)) begin
      errors++; $display("FAIL %s_grant5: got %b want id %0d", nm, if_a.grant, e5);
    end
    if_a.req = '0;
    cap(1'b0, 10);
    checks++;
    if ({if_a.busy, if_a.serial_out} !== 2'b01) begin
      errors++; $display("FAIL %s_idle: got busy=%b line=%b want 0/1", nm, if_a.busy, if_a.serial_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] wd [4];
    do_reset();
    wd[0] = 7'h11; wd[1] = 7'h22; wd[2] = 7'h33; wd[3] = 7'h44;
    run_held("b2b", 4'b1111, wd);
  endtask

  task automatic test_alternate();
    logic [6:0] wd [4];
    for (int i = 0; i < 4; i++) wd[i] = 7'($urandom);
    run_held("alt", 4'b0011, wd);
  endtask

  task automatic test_reset_mid();
    logic [6:0] w0, w1;
    int e;
    w0 = 7'($urandom);
    w1 = 7'($urandom);
    if_a.data_in[0 +: 7] = w0;
    if_a.req = 4'b0001;
    tick();
    if_a.req = '0;
    repeat (4) tick();
    checks++;
    if (if_a.serial_out !== w0[3]) begin
      errors++; $display("FAIL mid_d3: got %b want %b", if_a.serial_out, w0[3]);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({if_a.serial_out, if_a.busy, if_a.grant} !== 6'b1_0_0000) begin
      errors++; $display("FAIL mid_async: got line=%b busy=%b grant=%b want 1/0/0000",
                         if_a.serial_out, if_a.busy, if_a.grant);
    end
    if_a.data_in[7 +: 7] = w1;
    if_a.data_in[21 +: 7] = 7'($urandom);
    if_a.req = 4'b1010;
    mdl_last = 3;
    tick();
    checks++;
    if ({if_a.busy, if_a.grant} !== 5'b0_0000) begin
      errors++; $display("FAIL mid_held: got busy=%b grant=%b want 0/0000", if_a.busy, if_a.grant);
    end
    rstn = 1'b1;
    tick();
    e = rr_pick(mdl_last, 4'b1010);
    mdl_last = e;
    checks++;
    if ({if_a.grant, if_a.serial_out} !== {4'b0001 << e, 1'b0}) begin
      errors++; $display("FAIL mid_first_grant: got %b line=%b want id %0d", if_a.grant, if_a.serial_out, e);
    end
    if_a.req = '0;
    cap(1'b0, 11);
    for (int t = 1; t <= 10; t++) begin
      checks++;
      if ({cap_line[t], cap_busy[t]} !== {exp_line(w1, t), (t <= 9)}) begin
        errors++; $display("FAIL mid_frame_t%0d: got line=%b busy=%b want line=%b busy=%b",
                           t, cap_line[t], cap_busy[t], exp_line(w1, t), (t <= 9));
      end
    end
  endtask

  task automatic test_pulse();
    logic [3:0] seen;
    int e;
    if_a.data_in[7 +: 7] = 7'($urandom);
    if_a.req = 4'b0010;
    tick();
    e = rr_pick(mdl_last, 4'b0010);
    mdl_last = e;
    checks++;
    if (if_a.grant !== (4'b0001 << e)) begin
      errors++; $display("FAIL pulse_grant: got %b want id %0d", if_a.grant, e);
    end
    if_a.req = '0;
    seen = '0;
    for (int t = 1; t <= 11; t++) begin
      tick();
      seen = seen | if_a.grant;
      if (t == 3) if_a.req = 4'b1000;
      if (t == 4) if_a.req = 4'b0000;
    end
    checks++;
    if (seen !== 4'b0000) begin
      errors++; $display("FAIL pulse_no_grant: got %b want 0000", seen);
    end
    checks++;
    if ({if_a.busy, if_a.serial_out} !== 2'b01) begin
      errors++; $display("FAIL pulse_idle: got busy=%b line=%b want 0/1", if_a.busy, if_a.serial_out);
    end
  endtask

  task automatic test_random();
    logic [3:0] req_m, nm;
    logic [6:0] wd [4];
    logic [6:0] w;
    int e;
    for (int i = 0; i < 4; i++) begin
      wd[i] = 7'($urandom);
      if_a.data_in[7*i +: 7] = wd[i];
    end
    req_m = 4'($urandom_range(1, 15));
    if_a.req = req_m;
    tick();
    for (int f = 0; f < 8; f++) begin
      e = rr_pick(mdl_last, req_m);
      mdl_last = e;
      w = wd[e];
      checks++;
      if ({if_a.grant, if_a.cur_id} !== {4'b0001 << e, 2'(e)}) begin
        errors++; $display("FAIL rand_f%0d_grant: got %b/%0d want id %0d", f, if_a.grant, if_a.cur_id, e);
      end
      nm = (f < 7) ? 4'($urandom_range(1, 15)) : 4'b0000;
      for (int i = 0; i < 4; i++) begin
        if (nm[i] && (i == e || !req_m[i])) begin
          wd[i] = 7'($urandom);
          if_a.data_in[7*i +: 7] = wd[i];
        end
      end
      if_a.req = nm;
      for (int t = 1; t <= 9; t++) begin
        tick();
        checks++;
        if ({if_a.serial_out, if_a.busy, if_a.frame_done, if_a.grant} !==
            {exp_line(w, t), 1'b1, (t == 9), 4'b0000}) begin
          errors++;
          $display("FAIL rand_f%0d_t%0d: got line=%b busy=%b fd=%b grant=%b want line=%b fd=%b",
                   f, t, if_a.serial_out, if_a.busy, if_a.frame_done, if_a.grant, exp_line(w, t), (t == 9));
        end
      end
      tick();
      req_m = nm;
    end
    checks++;
    if ({if_a.busy, if_a.serial_out, if_a.grant} !== 6'b0_1_0000) begin
      errors++; $display("FAIL rand_idle: got busy=%b line=%b grant=%b want 0/1/0000",
                         if_a.busy, if_a.serial_out, if_a.grant);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stop3();
    test_back_to_back();
    test_alternate();
    test_reset_mid();
    test_pulse();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_tx_arbiter.md
# serial_tx_arbiter

Round-robin transmit scheduler for the 7-bit parity serial link. It shares one serial output line between N_REQ requesters. Each cycle it is free, it picks one pending requester, latches that requester's 7-bit word and serialises it as a frame: start bit, 7 data bits LSB first, even-parity bit, then stop bits. It sits on the transmit side of the link and drives the line the link receiver samples at one bit per clock.

## Interface
- N_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of cur_id; must equal clog2(N_REQ)
- STOP_CYCLES, 1, high cycles after the parity bit (>=1)
- clk  in  1  system clock; all logic on rising edge
- rstn  in  1  asynchronous, active-low reset
- req  in  N_REQ  request per requester, level-sensitive
- data_in  in  7*N_REQ  packed words; requester i at [7*i+6:7*i]; held stable while req[i]=1
- grant  out  N_REQ  one-hot, one-cycle pulse when a requester's word is latched
- serial_out  out  1  line output, registered, idles high
- busy  out  1  high while a frame is on the line (start through last stop cycle)
- cur_id  out  ID_W  index of the requester being sent; valid while busy=1
- frame_done  out  1  one-cycle pulse during the last stop cycle

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: serial_out=1, busy=0.
  - If any req bit is 1, choose the winner, latch data_in of the winner into shift_reg[6:0], and latch cur_id.
  - Compute parity = ^word (even parity: the 7 data bits plus the parity bit XOR to 0).
  - Pulse grant[winner] and go to START.
- Arbitration is round-robin. last_id holds the last grantee.
  - Search starts at last_id+1 and goes upward, wrapping modulo N_REQ; the first set req bit wins.
  - Reset sets last_id=N_REQ-1, so requester 0 has top priority after reset.
  - last_id updates on every grant.
- START: serial_out=0, one cycle, then DATA with bit_cnt=0.
- DATA: serial_out=shift_reg[bit_cnt] for bit_cnt=0..6, one cycle each, then PARITY.
- PARITY: serial_out=parity, one cycle, then STOP with stop_cnt=0.
- STOP: serial_out=1 for STOP_CYCLES cycles. frame_done=1 in the last stop cycle.
  - At the end of the last stop cycle, arbitration runs exactly as in IDLE. If a req is pending, go straight to START with a grant pulse; otherwise go to IDLE.
- Requester handshake:
  - The requester drops req[i] in the cycle it sees grant[i].
  - If req[i] is still 1 after the grant cycle, it is a new request.
  - A req pulse is honoured only if it is sampled at an arbitration edge.
- req and data_in changes outside arbitration edges have no effect on the frame in flight.
- Reset values: serial_out=1, grant=0, busy=0, cur_id=0, frame_done=0, state=IDLE, last_id=N_REQ-1.
- Reset mid-frame: the line returns high asynchronously, the frame is abandoned and no further grant is issued. The receiver sees a truncated frame; this is acceptable.

## Timing
- Cycle numbering: a req sampled in IDLE at edge k gives T0 = the cycle after edge k.
  - T0: grant pulse, busy=1, serial_out=0 (start bit).
  - T1..T7: d0..d6.
  - T8: parity bit.
  - T9..T(8+STOP_CYCLES): stop bits, serial_out=1.
- Earliest next start bit is at T(9+STOP_CYCLES). Back-to-back frame period is 9+STOP_CYCLES cycles (10 by default).
- busy is 1 from T0 through T(8+STOP_CYCLES). It stays 1 across back-to-back frames.
- All outputs are registered; there is no combinational path from req to grant.

## Test plan
- req[2]=1 with word 7'h55 after reset -> grant=4'b0100 at T0; serial_out T0..T9 = 0,1,0,1,0,1,0,1,0,1; loopback receiver gives data_out=7'h55, parity_ok_n=0.
- req[0]=1 with word 7'h01, STOP_CYCLES=3 -> parity bit=1; frame_done at T11; busy falls at T12; receiver gives parity_ok_n=0.
- req=4'b1111 held after reset, words 7'h11/22/33/44 -> grants 0,1,2,3 in order, start bits exactly 10 cycles apart, busy never drops.
- req[0] and req[1] held continuously -> grants alternate 0,1,0,1; no requester is granted twice in a row while the other waits.
- rstn low during DATA bit 3 -> serial_out=1, busy=0, grant=0 immediately; with req=4'b1010 after release, first grant goes to requester 1.
- One-cycle req[3] pulse during a frame (not at an arbitration edge) -> no grant[3]; the line returns to IDLE after the stop bit.
